// File: rtl/rotary_enc.sv
// rotary_enc: debounced quadrature encoder step counter with a read-and-clear snapshot interface.
// Ports:
//   aclk        - system clock, rising edge
//   reset       - asynchronous, active-high reset
//   ck, dt      - encoder channels A/B, asynchronous, idle high
//   read_enable - level request to fetch and clear the accumulated steps
//   out         - signed net detent count since the previous read
//   out_valid   - high while out answers the current read_enable
module rotary_enc #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   aclk,
  input  logic                   reset,
  input  logic                   ck,
  input  logic                   dt,
  input  logic                   read_enable,
  output logic [COUNT_WIDTH-1:0] out,
  output logic                   out_valid
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] ACC_MAX = {1'b0, {(COUNT_WIDTH-1){1'b1}}};
  localparam logic [COUNT_WIDTH-1:0] ACC_MIN = {1'b1, {(COUNT_WIDTH-1){1'b0}}};
  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);
  typedef enum logic {IDLE, HOLD} state_t;
  // bit 0 carries ck, bit 1 carries dt
  logic [1:0] r_s1, r_s2, r_db;
  logic [CW-1:0] r_cnt [2];
  logic r_ck_db_d;
  logic [COUNT_WIDTH-1:0] r_acc, w_acc_next;
  state_t r_state, w_state_next;
  logic w_snap, w_step, w_inc, w_dec;
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      r_s1 <= '1;
      r_s2 <= '1;
      r_db <= '1;
      r_cnt <= '{default: '0};
    end else begin
      r_s1 <= {dt, ck};
      r_s2 <= r_s1;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_db[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == CNT_MAX) begin
          r_db[i] <= r_s2[i];
          r_cnt[i] <= '0;
        end else r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end
  // a step is the cycle after debounced ck falls; direction from debounced dt
  always_comb begin
    w_step = r_ck_db_d & ~r_db[0];
    w_inc = w_step & r_db[1];
    w_dec = w_step & ~r_db[1];
  end
  always_comb begin
    w_snap = (r_state == IDLE) && read_enable;
    w_state_next = w_snap ? HOLD : (r_state == HOLD && !read_enable) ? IDLE : r_state;
  end
  // a step landing on the snapshot cycle seeds the cleared accumulator instead of being lost
  always_comb begin
    w_acc_next = w_snap ? (w_inc ? ONE : w_dec ? '1 : '0)
      : (w_inc && r_acc != ACC_MAX) ? r_acc + ONE
      : (w_dec && r_acc != ACC_MIN) ? r_acc - ONE
      : r_acc;
  end
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_state_next;
  end
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      r_ck_db_d <= 1'b1;
      r_acc <= '0;
      out <= '0;
    end else begin
      r_ck_db_d <= r_db[0];
      r_acc <= w_acc_next;
      if (w_snap) out <= r_acc;
    end
  end
  always_comb out_valid = (r_state == HOLD);
endmodule

// File: tb/tb_rotary_enc.sv
// tb_rotary_enc: directed and randomized bench for rotary_enc against a detent-level count model.
module tb_rotary_enc;
  logic aclk = 0, reset = 0, ck = 1, dt = 1, read_enable = 0;
  logic [7:0] out;
  logic out_valid;
  int checks = 0, errors = 0, model = 0, last = 0;
  logic hold_chk = 0;
  logic signed [31:0] hold_val = 0;

  rotary_enc #(.DEBOUNCE_CYCLES(4), .COUNT_WIDTH(8)) dut (
    .aclk(aclk), .reset(reset), .ck(ck), .dt(dt),
    .read_enable(read_enable), .out(out), .out_valid(out_valid)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge aclk);
      #1;
      if (hold_chk) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_out", $signed(out), hold_val);
      end
    end
  endtask

  function automatic int clamp(int v);
    return v > 127 ? 127 : v < -128 ? -128 : v;
  endfunction

  task automatic detent(bit cw);
    if (!cw) begin dt = 0; tick(10); end
    ck = 0; tick(10);
    model = clamp(model + (cw ? 1 : -1));
    ck = 1; tick(10);
    if (!cw) begin dt = 1; tick(10); end
  endtask

  task automatic do_read(string tag, int hold, int ndet);
    chk({tag, "_idle"}, out_valid, 0);
    read_enable = 1; tick();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_out"}, $signed(out), model);
    last = model; model = 0;
    hold_val = last; hold_chk = 1;
    tick(hold);
    repeat (ndet) detent(1);
    hold_chk = 0;
    read_enable = 0; tick();
    chk({tag, "_drop"}, out_valid, 0);
    chk({tag, "_keep"}, $signed(out), last);
  endtask

  initial begin
    int o1, o2;
    bit seen;
    #1 reset = 1;
    #20;
    chk("rst_valid", out_valid, 0);
    chk("rst_out", $signed(out), 0);
    @(negedge aclk) reset = 0;
    tick(5);
    do_read("post_reset", 0, 0);
    // clean CW detents, then an empty second read
    repeat (3) detent(1);
    do_read("cw3", 2, 0);
    do_read("empty", 0, 0);
    // CCW detents and a short ck glitch
    repeat (2) detent(0);
    ck = 0; tick(2); ck = 1; tick(10);
    do_read("ccw_glitch", 1, 0);
    // saturation both ways
    repeat (200) detent(1);
    do_read("sat_hi", 0, 0);
    repeat (200) detent(0);
    do_read("sat_lo", 0, 0);
    // sweep the read start across the step so one snapshot coincides with it
    seen = 0;
    for (int k = 0; k <= 12; k++) begin
      repeat (5) detent(1);
      ck = 0; tick(k);
      read_enable = 1; tick();
      chk("sweep_valid", out_valid, 1);
      o1 = $signed(out);
      read_enable = 0; tick();
      tick(k < 8 ? 8 - k : 0);
      ck = 1; tick(10);
      read_enable = 1; tick();
      o2 = $signed(out);
      read_enable = 0; tick();
      chk("sweep_sum", o1 + o2, 6);
      chk("sweep_range", (o1 == 5 || o1 == 6), 1);
      if (o1 == 5 && o2 == 1) seen = 1;
      model = 0;
    end
    chk("sweep_excl_seen", seen, 1);
    // long hold with steps accumulating underneath
    repeat (2) detent(0);
    do_read("long_hold", 50, 4);
    do_read("after_hold", 0, 0);
    // randomized detents and reads
    repeat (40) begin
      if ($urandom_range(0, 3) == 0) do_read("rand", $urandom_range(0, 5), 0);
      else detent($urandom_range(0, 1) == 1);
    end
    do_read("rand_final", 0, 0);
    // reset during HOLD
    repeat (4) detent(1);
    read_enable = 1; tick();
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_out", $signed(out), 4);
    #2 reset = 1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_out", $signed(out), 0);
    model = 0;
    @(negedge aclk) reset = 0;
    tick();
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_out", $signed(out), 0);
    read_enable = 0; tick();
    chk("post_rst_drop", out_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rotary_enc.md
ROTARY_ENC -- requirements
Module: rotary_enc

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 100000, meaning consecutive aclk cycles a synchronized input must hold a new level before it is accepted (1 ms at 100 MHz).
REQ-002 SHALL have parameter COUNT_WIDTH, default 8, meaning width of the signed step accumulator and of out.
REQ-003 SHALL have port aclk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ck  input  1  encoder channel A; asynchronous to aclk; idles high (pull-up).
REQ-006 SHALL have port dt  input  1  encoder channel B; asynchronous to aclk; idles high.
REQ-007 SHALL have port read_enable  input  1  level request from the command dispatcher to fetch and clear the accumulated steps.
REQ-008 SHALL have port out  output  COUNT_WIDTH  signed net detent count since the previous read.
REQ-009 SHALL have port out_valid  output  1  high while out holds a snapshot answering the current read_enable.

Function
REQ-010 SHALL pass ck and dt each through a 2-flop synchronizer before any other use.
REQ-011 SHALL debounce each synchronized channel independently, with a separate counter per channel.
REQ-012 Debounce counter SHALL clear whenever the synchronized level equals the debounced level.
REQ-013 Debounced level SHALL take the synchronized level on the cycle the counter reaches DEBOUNCE_CYCLES-1 while the two levels differ; the counter SHALL then clear.
REQ-014 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave the debounced level unchanged.
REQ-015 SHALL generate a step only on a falling edge (1->0) of debounced ck: debounced dt=1 -> +1 (clockwise), debounced dt=0 -> -1; one step per detent.
REQ-016 Rising edges of debounced ck and all edges of debounced dt SHALL generate no step.
REQ-017 Accumulator SHALL saturate at +(2^(COUNT_WIDTH-1))-1 and -(2^(COUNT_WIDTH-1)); a step past a limit SHALL leave the value at that limit (127 / -128 at default), never wrap.
REQ-018 Read FSM states SHALL be IDLE and HOLD.
REQ-019 IDLE, read_enable=1: next edge SHALL load out with the accumulator, set out_valid=1, clear the accumulator, and enter HOLD; out_valid latency is 1 cycle after read_enable is sampled high.
REQ-020 A step coinciding with the snapshot cycle SHALL be excluded from out and SHALL set the new accumulator to +1 or -1; no step SHALL be lost or double-counted.
REQ-021 HOLD: out and out_valid SHALL stay constant while read_enable=1; steps SHALL keep accumulating.
REQ-022 HOLD, read_enable=0: next edge SHALL clear out_valid and enter IDLE; out SHALL keep its last value.
REQ-023 IDLE, read_enable=0: out_valid SHALL stay 0.
REQ-024 Only one snapshot SHALL occur per read_enable high period, however long it lasts.

Reset
REQ-025 reset SHALL asynchronously force: synchronizer flops and debounced levels to 1; debounce counters, accumulator and out to 0; out_valid to 0; FSM to IDLE.
REQ-026 reset asserted mid-read (HOLD) SHALL drop out_valid immediately and discard the accumulated count; after release with read_enable still 1, a fresh read SHALL return 0 one cycle later.
REQ-027 The first aclk edge after reset release SHALL process normally; no step SHALL result from the reset-to-input transition when inputs are idle high.

Verification (DEBOUNCE_CYCLES=4, COUNT_WIDTH=8)
REQ-028 3 clean CW detents (ck falls with dt=1, each level held 10 cycles), then read_enable=1 -> out_valid=1 one cycle later, out=3; read_enable=0 -> out_valid=0 next cycle; second read -> out=0.
REQ-029 2 CCW detents, then 2-cycle low glitch on ck -> read returns -2; glitch adds no step.
REQ-030 200 CW detents -> read returns 127; 200 CCW detents after the read -> next read returns -128.
REQ-031 Step timed to land in the snapshot cycle after 5 prior CW steps -> out=5; next read returns 1.
REQ-032 read_enable held 50 cycles while 4 CW steps occur -> out and out_valid constant; the following read returns 4.
REQ-033 4 steps then reset pulse during HOLD -> out_valid=0 and out=0 asynchronously; read after release returns 0.
